// File: rtl/significand_mult_seq.sv
// significand_mult_seq: multi-cycle shift-add significand multiplier.
// Normalises the product and rounds it to MANT_WIDTH bits.
//
// Ports
//   i_clk          rising-edge clock
//   i_reset        synchronous active-high reset
//   i_in_valid     operand request
//   o_in_ready     block can accept (IDLE)
//   i_mant_a       fraction of operand A
//   i_mant_b       fraction of operand B
//   i_hidden_a     hidden bit of A
//   i_hidden_b     hidden bit of B
//   o_out_valid    result available (DONE)
//   i_out_ready    downstream accepts result
//   o_result       normalised, rounded fraction
//   o_norm_shift   product >= 2.0, exponent +1
//   o_round_carry  rounding wrapped fraction to 0
//
// Build option: SIGMUL_RNE_EN selects round-to-nearest-even;
// without it the fraction is truncated.
module significand_mult_seq #(
   parameter int MANT_WIDTH = 10,
   parameter int RADIX_BITS = 1
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_in_valid,
   output logic                  o_in_ready,
   input  logic [MANT_WIDTH-1:0] i_mant_a,
   input  logic [MANT_WIDTH-1:0] i_mant_b,
   input  logic                  i_hidden_a,
   input  logic                  i_hidden_b,
   output logic                  o_out_valid,
   input  logic                  i_out_ready,
   output logic [MANT_WIDTH-1:0] o_result,
   output logic                  o_norm_shift,
   output logic                  o_round_carry
);

   localparam int W    = MANT_WIDTH + 1;
   localparam int ITER = (W + RADIX_BITS - 1) / RADIX_BITS;
   localparam int BW   = ITER * RADIX_BITS;
   localparam int CW   = $clog2(ITER);

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_ROUND,
      S_DONE
   } state_t;

   state_t r_state;
   state_t w_next;

   logic [2*W-1:0]        r_a;
   logic [BW-1:0]         r_b;
   logic [2*W-1:0]        r_acc;
   logic [CW-1:0]         r_cnt;
   logic [MANT_WIDTH-1:0] r_result;
   logic                  r_ns;
   logic                  r_rc;

   logic [2*W-1:0]        w_pp;
   logic                  w_ns;
   logic [MANT_WIDTH-1:0] w_frac;
   logic [MANT_WIDTH-1:0] w_res;
   logic                  w_rc;

   // Partial product for the multiplier digit at the bottom of r_b.
   generate
      if (RADIX_BITS == 2) begin : g_r4
         always_comb begin
            w_pp = '0;
            case (r_b[1:0])
               2'd0:    w_pp = '0;
               2'd1:    w_pp = r_a;
               2'd2:    w_pp = r_a << 1;
               default: w_pp = r_a + (r_a << 1);
            endcase
         end
      end else begin : g_r2
         always_comb begin
            w_pp = '0;
            if (r_b[0]) w_pp = r_a;
         end
      end
   endgenerate

   // Normalise: drop the leading one, keep MANT_WIDTH bits.
   assign w_ns   = r_acc[2*W-1];
   assign w_frac = w_ns ? r_acc[2*W-2:W]
                        : r_acc[2*W-3:W-1];

`ifdef SIGMUL_RNE_EN
   logic                  w_guard;
   logic                  w_sticky;
   logic                  w_inc;
   logic [MANT_WIDTH:0]   w_sum;

   assign w_guard  = w_ns ? r_acc[W-1] : r_acc[W-2];
   assign w_sticky = w_ns ? |r_acc[W-2:0]
                          : |r_acc[W-3:0];
   assign w_inc    = w_guard & (w_sticky | w_frac[0]);
   assign w_sum    = {1'b0, w_frac}
                   + {{MANT_WIDTH{1'b0}}, w_inc};
   assign w_res    = w_sum[MANT_WIDTH-1:0];
   assign w_rc     = w_sum[MANT_WIDTH];
`else
   // Bits below the kept fraction are simply dropped.
   logic w_unused;
   assign w_unused = &{1'b0, r_acc[W-2:0]};
   assign w_res    = w_frac;
   assign w_rc     = 1'b0;
`endif

   always_ff @(posedge i_clk) begin
      if (i_reset) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  if (i_in_valid) w_next = S_MUL;
         S_MUL:   if (r_cnt == CW'(ITER - 1)) w_next = S_ROUND;
         S_ROUND: w_next = S_DONE;
         S_DONE:  if (i_out_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_a      <= '0;
         r_b      <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_result <= '0;
         r_ns     <= 1'b0;
         r_rc     <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (i_in_valid) begin
                  r_a   <= (2*W)'({i_hidden_a, i_mant_a});
                  r_b   <= BW'({i_hidden_b, i_mant_b});
                  r_acc <= '0;
                  r_cnt <= '0;
               end
            end
            S_MUL: begin
               r_acc <= r_acc + w_pp;
               r_a   <= r_a << RADIX_BITS;
               r_b   <= r_b >> RADIX_BITS;
               r_cnt <= r_cnt + 1'b1;
            end
            S_ROUND: begin
               r_result <= w_res;
               r_ns     <= w_ns;
               r_rc     <= w_rc;
            end
            default: begin
            end
         endcase
      end
   end

   assign o_in_ready    = (r_state == S_IDLE);
   assign o_out_valid   = (r_state == S_DONE);
   assign o_result      = r_result;
   assign o_norm_shift  = r_ns;
   assign o_round_carry = r_rc;

endmodule

// File: tb/tb_significand_mult_seq.sv
// tb_significand_mult_seq: radix-2 and radix-4 instances run
// in lock-step against a behavioural product/rounding model.
module tb_significand_mult_seq;

   localparam int M = 10;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic [M-1:0] ma = '0;
   logic [M-1:0] mb = '0;
   logic         ha = 1'b0;
   logic         hb = 1'b0;

   logic         ir0, ov0, ns0, rc0;
   logic         ir1, ov1, ns1, rc1;
   logic [M-1:0] res0, res1;

   int           tests = 0;
   int           fails = 0;
   int           cyc = 0;
   int           acc_cyc = 0;
   int           txn = 0;
   int           seen [2];
   logic         quiet = 1'b0;
   logic         idle_chk = 1'b0;
   logic [M-1:0] exp_r = '0;
   logic         exp_ns = 1'b0;
   logic         exp_rc = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   significand_mult_seq #(.MANT_WIDTH(M), .RADIX_BITS(1)) u_r2 (
      .i_clk(clk), .i_reset(reset),
      .i_in_valid(in_valid), .o_in_ready(ir0),
      .i_mant_a(ma), .i_mant_b(mb),
      .i_hidden_a(ha), .i_hidden_b(hb),
      .o_out_valid(ov0), .i_out_ready(out_ready),
      .o_result(res0), .o_norm_shift(ns0),
      .o_round_carry(rc0)
   );

   significand_mult_seq #(.MANT_WIDTH(M), .RADIX_BITS(2)) u_r4 (
      .i_clk(clk), .i_reset(reset),
      .i_in_valid(in_valid), .o_in_ready(ir1),
      .i_mant_a(ma), .i_mant_b(mb),
      .i_hidden_a(ha), .i_hidden_b(hb),
      .o_out_valid(ov1), .i_out_ready(out_ready),
      .o_result(res1), .o_norm_shift(ns1),
      .o_round_carry(rc1)
   );

   // Exact product of two 1.f significands, then normalise and round.
   function automatic void model(
      input  logic [M-1:0] a, input logic [M-1:0] b,
      input  logic pa, input logic pb,
      output logic [M-1:0] r, output logic nsh,
      output logic rcy);
      logic [63:0] p, q, rem, half, s;
      int lo;
      logic up;
      p    = 64'({pa, a}) * 64'({pb, b});
      nsh  = (p >= (64'd1 << 21));
      lo   = nsh ? 11 : 10;
      q    = p >> lo;
      rem  = p - (q << lo);
      half = 64'd1 << (lo - 1);
      up   = 1'b0;
`ifdef SIGMUL_RNE_EN
      up = (rem > half) || ((rem == half) && q[0]);
`endif
      s   = (q & 64'h3FF) + 64'(up);
      r   = s[M-1:0];
      rcy = s[M];
   endfunction

   task automatic chk(input string n, input int k,
                      input int act, input int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s dut%0d txn%0d actual=%0h required=%0h",
                  n, k, txn, act, req);
      end
   endtask

   task automatic check_dut(input int k, input logic ir,
                            input logic ov, input logic [M-1:0] r,
                            input logic nsh, input logic rcy);
      if (quiet) begin
         chk("rst_in_ready", k, int'(ir), 1);
         chk("rst_out_valid", k, int'(ov), 0);
         chk("rst_result", k, int'(r), 0);
         chk("rst_norm_shift", k, int'(nsh), 0);
         chk("rst_round_carry", k, int'(rcy), 0);
      end
      if (idle_chk) begin
         chk("release_in_ready", k, int'(ir), 1);
         chk("release_out_valid", k, int'(ov), 0);
      end
      if (ov) begin
         if (seen[k] != txn) begin
            chk("latency", k, cyc - acc_cyc, (k == 0) ? 12 : 7);
            seen[k] = txn;
         end
         chk("result", k, int'(r), int'(exp_r));
         chk("norm_shift", k, int'(nsh), int'(exp_ns));
         chk("round_carry", k, int'(rcy), int'(exp_rc));
         chk("busy_in_ready", k, int'(ir), 0);
      end
   endtask

   always @(negedge clk) begin
      check_dut(0, ir0, ov0, res0, ns0, rc0);
      check_dut(1, ir1, ov1, res1, ns1, rc1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic timeout(input string n);
      $display("FAIL timeout %s txn%0d", n, txn);
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1, "timeout");
   endtask

   task automatic wait_idle();
      int n = 0;
      while (!(ir0 && ir1)) begin
         step();
         n++;
         if (n > 100) timeout("in_ready");
      end
   endtask

   task automatic run(input logic [M-1:0] a, input logic [M-1:0] b,
                      input logic pa, input logic pb,
                      input logic [M-1:0] er, input logic ens,
                      input logic erc, input logic hold);
      int n = 0;
      logic [1:0] got = 2'b00;
      wait_idle();
      ma = a; mb = b; ha = pa; hb = pb;
      exp_r = er; exp_ns = ens; exp_rc = erc;
      txn++;
      out_ready = !hold;
      in_valid = 1'b1;
      step();
      acc_cyc = cyc;
      in_valid = 1'b0;
      while (got != 2'b11) begin
         step();
         got = got | {ov1, ov0};
         n++;
         if (n > 60) timeout("out_valid");
      end
      if (hold) begin
         repeat (5) step();
         out_ready = 1'b1;
         step();
         idle_chk = 1'b1;
         step();
         idle_chk = 1'b0;
      end else begin
         step();
      end
      out_ready = 1'b0;
   endtask

   task automatic run_model(input logic [M-1:0] a,
                            input logic [M-1:0] b,
                            input logic pa, input logic pb,
                            input logic hold);
      logic [M-1:0] r;
      logic nsh, rcy;
      model(a, b, pa, pb, r, nsh, rcy);
      run(a, b, pa, pb, r, nsh, rcy, hold);
   endtask

   task automatic reset_mid_op();
      wait_idle();
      ma = 10'h2A5; mb = 10'h1C3; ha = 1'b1; hb = 1'b1;
      txn++;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      repeat (3) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      quiet = 1'b1;
      repeat (16) step();
      quiet = 1'b0;
   endtask

   initial begin
      seen[0] = 0;
      seen[1] = 0;
      repeat (3) step();
      reset = 1'b0;
      quiet = 1'b1;
      repeat (2) step();
      quiet = 1'b0;

      // 1.5 * 1.5 = 2.25
      run(10'h200, 10'h200, 1, 1, 10'h080, 1, 0, 0);
      // 1.0 * 1.0 with backpressure
      run(10'h000, 10'h000, 1, 1, 10'h000, 0, 0, 1);
`ifdef SIGMUL_RNE_EN
      run(10'h001, 10'h200, 1, 1, 10'h202, 0, 0, 0);
      run(10'h155, 10'h200, 1, 1, 10'h000, 0, 1, 1);
`else
      run(10'h001, 10'h200, 1, 1, 10'h201, 0, 0, 0);
      run(10'h155, 10'h200, 1, 1, 10'h3FF, 0, 0, 1);
`endif
      run(10'h003, 10'h200, 1, 1, 10'h204, 0, 0, 1);
      // zero operands
      run(10'h000, 10'h000, 0, 0, 10'h000, 0, 0, 0);
      run(10'h3FF, 10'h000, 1, 0, 10'h000, 0, 0, 1);

      reset_mid_op();

      run_model(10'h3FF, 10'h3FF, 1, 1, 0);
      for (int i = 0; i < 40; i++) begin
         run_model(M'($urandom), M'($urandom),
                   ($urandom_range(0, 7) != 0),
                   ($urandom_range(0, 7) != 0),
                   $urandom_range(0, 1) == 1);
      end

      repeat (2) step();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
